// File: rtl/ama_riscv_icache_sa_if.sv
// Valid/ready channel shared by the core and memory sides of the instruction cache.
// TX drives valid/data and observes ready; RX is the mirror view.
interface rv_if #(
    parameter int DW = 32
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport TX (output valid, output data, input ready);
    modport RX (input valid, input data, output ready);
endinterface

// File: rtl/ama_riscv_icache_sa.sv
// Set-associative (1 or 2 way) instruction cache with 64B lines, 4x128-bit fills
// from main memory, LRU replacement and a one-set-per-cycle invalidate sweep.
module ama_riscv_icache_sa #(
    parameter int SETS            = 4,
    parameter int WAYS            = 2,
    parameter int CORE_ADDR_BUS_W = 32,
    parameter int MEM_ADDR_BUS    = 32
) (
    input  logic clk,
    input  logic rst,
    rv_if.RX     req_core,
    rv_if.TX     rsp_core,
    rv_if.TX     req_mem,
    rv_if.RX     rsp_mem,
    input  logic flush_req,
    output logic flush_done
);
    localparam int LINE_W   = 512;
    localparam int LOG_SETS = $clog2(SETS);
    localparam int IDX_W    = (LOG_SETS > 0) ? LOG_SETS : 1;
    localparam int TAG_W    = CORE_ADDR_BUS_W - 4 - LOG_SETS;
    localparam logic [CORE_ADDR_BUS_W-1:0] IDX_MASK = CORE_ADDR_BUS_W'(SETS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    if ((WAYS != 1) && (WAYS != 2)) begin : g_bad_ways
        $error("ama_riscv_icache_sa: WAYS must be 1 or 2");
    end
    if ((SETS < 1) || ((SETS & (SETS - 1)) != 0) || (SETS * WAYS > 1024)) begin : g_bad_sets
        $error("ama_riscv_icache_sa: SETS must be a power of 2 with SETS*WAYS <= 1024");
    end

    typedef enum logic [1:0] {IC_RESET, IC_READY, IC_MISS, IC_FLUSH} ic_state_t;

    function automatic logic [IDX_W-1:0] idx_of(input logic [CORE_ADDR_BUS_W-1:0] a);
        return IDX_W'((a >> 4) & IDX_MASK);
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [CORE_ADDR_BUS_W-1:0] a);
        return TAG_W'(a >> (4 + LOG_SETS));
    endfunction

    ic_state_t                  r_state, w_state_nxt;
    logic [SETS-1:0]            r_valid [WAYS];
    logic [TAG_W-1:0]           r_tag   [WAYS][SETS];
    logic [LINE_W-1:0]          r_data  [WAYS][SETS];
    logic [SETS-1:0]            r_lru;
    logic [CORE_ADDR_BUS_W-1:0] r_addr;
    logic [2:0]                 r_req_cnt;
    logic [1:0]                 r_rsp_cnt;
    logic                       r_victim;
    logic [31:0]                r_fill_word;
    logic [IDX_W-1:0]           r_flush_idx;
    logic                       r_rsp_valid;
    logic [31:0]                r_rsp_data;

    logic [IDX_W-1:0]        w_idx, w_fill_idx;
    logic [TAG_W-1:0]        w_tag;
    logic [WAYS-1:0]         w_match;
    logic                    w_hit, w_hit_way, w_victim;
    logic [31:0]             w_hit_word, w_fill_word;
    logic                    w_core_hs, w_mem_hs, w_beat, w_last_beat;
    logic [MEM_ADDR_BUS-1:0] w_base;
    logic                    w_unused;

    assign w_idx      = idx_of(req_core.data);
    assign w_tag      = tag_of(req_core.data);
    assign w_fill_idx = idx_of(r_addr);
    assign w_base     = MEM_ADDR_BUS'(r_addr >> 2) & ~MEM_ADDR_BUS'(3);
    assign w_unused   = rsp_core.ready;

    // Tag compare across the ways of the addressed set.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_match[w] = r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
        end
        w_hit      = |w_match;
        w_hit_way  = (WAYS == 2) ? w_match[WAYS-1] : 1'b0;
        w_hit_word = r_data[w_hit_way][w_idx][{req_core.data[3:0], 5'd0} +: 32];
        w_victim   = (WAYS == 1)                 ? 1'b0 :
                     (!r_valid[0][w_idx])        ? 1'b0 :
                     (!r_valid[WAYS-1][w_idx])   ? 1'b1 : r_lru[w_idx];
    end

    assign req_core.ready = !rst && (r_state == IC_READY) && !flush_req;
    assign req_mem.valid  = !rst && (r_state == IC_MISS) && !r_req_cnt[2];
    assign req_mem.data   = req_mem.valid ? (w_base | MEM_ADDR_BUS'(r_req_cnt[1:0])) : '0;
    assign rsp_mem.ready  = !rst && (r_state == IC_MISS);
    assign rsp_core.valid = r_rsp_valid;
    assign rsp_core.data  = r_rsp_data;
    assign flush_done     = !rst && (r_state == IC_FLUSH) && (r_flush_idx == LAST_IDX);

    assign w_core_hs   = req_core.valid && req_core.ready;
    assign w_mem_hs    = req_mem.valid && req_mem.ready;
    assign w_beat      = rsp_mem.valid && rsp_mem.ready;
    assign w_last_beat = w_beat && (r_rsp_cnt == 2'd3);
    // The missed word may sit in the beat arriving right now, so bypass it.
    assign w_fill_word = (r_rsp_cnt == r_addr[3:2]) ?
                         rsp_mem.data[{r_addr[1:0], 5'd0} +: 32] : r_fill_word;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IC_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IC_RESET: w_state_nxt = IC_READY;
            IC_READY: begin
                if (flush_req) begin
                    w_state_nxt = IC_FLUSH;
                end else if (w_core_hs && !w_hit) begin
                    w_state_nxt = IC_MISS;
                end else begin
                    w_state_nxt = IC_READY;
                end
            end
            IC_MISS: begin
                if (w_last_beat) begin
                    w_state_nxt = IC_READY;
                end else begin
                    w_state_nxt = IC_MISS;
                end
            end
            IC_FLUSH: begin
                if (r_flush_idx == LAST_IDX) begin
                    w_state_nxt = IC_READY;
                end else begin
                    w_state_nxt = IC_FLUSH;
                end
            end
            default: w_state_nxt = IC_RESET;
        endcase
    end

    // Valid/LRU bookkeeping, miss tracking and the registered core response.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
            end
            r_lru       <= '0;
            r_addr      <= '0;
            r_req_cnt   <= 3'd0;
            r_rsp_cnt   <= 2'd0;
            r_victim    <= 1'b0;
            r_fill_word <= 32'd0;
            r_flush_idx <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            case (r_state)
                IC_READY: begin
                    if (w_core_hs && w_hit) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_hit_word;
                        if (WAYS == 2) r_lru[w_idx] <= ~w_hit_way;
                    end else if (w_core_hs) begin
                        r_addr    <= req_core.data;
                        r_victim  <= w_victim;
                        r_req_cnt <= 3'd0;
                        r_rsp_cnt <= 2'd0;
                    end
                end
                IC_MISS: begin
                    if (w_mem_hs) r_req_cnt <= r_req_cnt + 3'd1;
                    if (w_beat) begin
                        r_rsp_cnt   <= r_rsp_cnt + 2'd1;
                        r_fill_word <= w_fill_word;
                    end
                    if (w_last_beat) begin
                        r_valid[r_victim][w_fill_idx] <= 1'b1;
                        if (WAYS == 2) r_lru[w_fill_idx] <= ~r_victim;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_fill_word;
                    end
                end
                IC_FLUSH: begin
                    for (int w = 0; w < WAYS; w++) begin
                        r_valid[w][r_flush_idx] <= 1'b0;
                    end
                    r_lru[r_flush_idx] <= 1'b0;
                    r_flush_idx <= (r_flush_idx == LAST_IDX) ? '0 : r_flush_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: unreset storage, qualified only by valid.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_data[r_victim][w_fill_idx][{r_rsp_cnt, 7'd0} +: 128] <= rsp_mem.data;
        end
        if (w_last_beat) begin
            r_tag[r_victim][w_fill_idx] <= tag_of(r_addr);
        end
    end
endmodule

// File: tb/tb_ama_riscv_icache_sa.sv
// Bench for ama_riscv_icache_sa: vector table of fetches with hit/miss expectations,
// a latency-randomising memory model and hand-written stall, flush and reset sequences.
module tb_ama_riscv_icache_sa;
    localparam int SETS = 4;
    localparam int WAYS = 2;

    logic clk = 1'b0;
    logic rst;
    logic flush_req;
    logic flush_done;

    rv_if #(.DW(32))  req_core ();
    rv_if #(.DW(32))  rsp_core ();
    rv_if #(.DW(32))  req_mem ();
    rv_if #(.DW(128)) rsp_mem ();

    ama_riscv_icache_sa #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_core   (req_core),
        .rsp_core   (rsp_core),
        .req_mem    (req_mem),
        .rsp_mem    (rsp_mem),
        .flush_req  (flush_req),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          hit;
    } vec_t;

    int          n_vec  = 0;
    int          n_err  = 0;
    int          n_hs   = 0;
    int          n_rsp  = 0;
    int          n_fd   = 0;
    int          n_beats = 0;
    bit          stall_en = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] mreq_log[$];
    logic [31:0] stall_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [127:0] mem_beat(input logic [31:0] blk);
        logic [127:0] b;
        for (int j = 0; j < 4; j++) begin
            b[32*j +: 32] = mem_word({blk[29:0], 2'b00} + 32'(j));
        end
        return b;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic finish_now();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic idle_chk(input string nm);
        check(nm, 128'({rsp_core.valid, req_core.ready, req_mem.valid, rsp_mem.ready, flush_done,
                        (rsp_core.data != 32'd0), (req_mem.data != 32'd0)}), 128'd0);
    endtask

    // Single fetch: handshake, then compare latency, memory traffic and data.
    task automatic fetch(input logic [31:0] a, input bit exp_hit);
        int t;
        int lat;
        int m0;
        logic [31:0] base;
        m0   = mreq_log.size();
        base = (a >> 2) & ~32'd3;
        req_core.valid = 1'b1;
        req_core.data  = a;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_core.ready && t < 200);
        if (!req_core.ready) begin
            n_err++;
            $display("FAIL accept_timeout: addr %0h never accepted", a);
            finish_now();
        end
        @(posedge clk);
        #1;
        n_hs++;
        exp_q.push_back(mem_word(a));
        req_core.valid = 1'b0;
        req_core.data  = 32'd0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_core.valid && lat < 300);
        if (!rsp_core.valid) begin
            n_err++;
            $display("FAIL rsp_timeout: addr %0h no response", a);
            finish_now();
        end
        check($sformatf("rsp_data@%0h", a), 128'(rsp_core.data), 128'(exp_q.pop_front()));
        if (exp_hit) check($sformatf("hit_latency@%0h", a), 128'(lat), 128'd1);
        check($sformatf("mem_reqs@%0h", a), 128'(mreq_log.size() - m0), exp_hit ? 128'd0 : 128'd4);
        if (!exp_hit && (mreq_log.size() - m0 == 4)) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("mem_addr%0d@%0h", k, a), 128'(mreq_log[m0+k]), 128'(base + 32'(k)));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Response and flush_done counters.
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_core.valid) n_rsp++;
            if (flush_done) n_fd++;
        end
    end

    // Main memory: queues block requests, returns beats in order after random latency.
    initial begin : mem_model
        logic [31:0] pend[$];
        logic [31:0] blk;
        int lat;
        int s;
        bit fire;
        lat = 0;
        s = 0;
        req_mem.ready = 1'b1;
        rsp_mem.valid = 1'b0;
        rsp_mem.data  = '0;
        forever begin
            @(negedge clk);
            if (req_mem.valid && req_mem.ready) begin
                pend.push_back(req_mem.data);
                mreq_log.push_back(req_mem.data);
            end
            fire = rsp_mem.valid && rsp_mem.ready;
            if (fire) n_beats++;
            @(posedge clk);
            #1;
            if (fire) begin
                rsp_mem.valid = 1'b0;
                rsp_mem.data  = '0;
                lat = $urandom_range(0, 2);
            end
            if (rst) begin
                pend.delete();
                rsp_mem.valid = 1'b0;
                rsp_mem.data  = '0;
            end else if (!rsp_mem.valid && pend.size() > 0) begin
                if (lat > 0) begin
                    lat--;
                end else begin
                    blk = pend.pop_front();
                    rsp_mem.valid = 1'b1;
                    rsp_mem.data  = mem_beat(blk);
                end
            end
            if (stall_en && req_mem.valid && req_mem.data[1:0] == 2'd2 && s < 3) begin
                req_mem.ready = 1'b0;
                s++;
                stall_log.push_back(req_mem.data);
            end else begin
                req_mem.ready = 1'b1;
                if (!(req_mem.valid && req_mem.data[1:0] == 2'd2)) s = 0;
            end
        end
    end

    initial begin
        vec_t vt [13];
        int k;
        int t;
        int fd0;
        int b0;
        vt = '{'{32'h0010, 1'b0}, '{32'h0011, 1'b1}, '{32'h001F, 1'b1}, '{32'h0000, 1'b0},
               '{32'h0040, 1'b0}, '{32'h0000, 1'b1}, '{32'h0080, 1'b0}, '{32'h0000, 1'b1},
               '{32'h0047, 1'b0}, '{32'h001C, 1'b1}, '{32'h3A5C, 1'b0}, '{32'h3A53, 1'b1},
               '{32'h0013, 1'b1}};
        rst = 1'b1;
        flush_req = 1'b0;
        req_core.valid = 1'b0;
        req_core.data  = 32'd0;
        rsp_core.ready = 1'b1;

        @(negedge clk);
        idle_chk("idle_in_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        idle_chk("idle_after_reset");
        @(negedge clk);
        check("ready_after_reset", 128'(req_core.ready), 128'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            fetch(vt[i].addr, vt[i].hit);
        end

        // Beat 2 held off by memory for 3 cycles; address must stay put.
        stall_en = 1'b1;
        fetch(32'h0405, 1'b0);
        stall_en = 1'b0;
        check("stall_cycles", 128'(stall_log.size()), 128'd3);
        for (int j = 0; j < stall_log.size(); j++) begin
            check("stall_addr", 128'(stall_log[j]), 128'h102);
        end
        fetch(32'h040E, 1'b1);

        // Flush raised mid-fill: fill completes first, then the sweep.
        fd0 = n_fd;
        fork
            fetch(32'h0300, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1;
                flush_req = 1'b1;
            end
        join
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!flush_done && k < 50);
        check("flush_sweep_cycles", 128'(k), 128'(SETS));
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        repeat (3) @(negedge clk);
        check("flush_done_pulses", 128'(n_fd - fd0), 128'd1);
        @(posedge clk);
        #1;
        fetch(32'h0300, 1'b0);
        fetch(32'h0011, 1'b0);

        // Reset after beat 1 of a fill abandons it.
        b0 = n_beats;
        req_core.valid = 1'b1;
        req_core.data  = 32'h0500;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_core.ready && t < 200);
        @(posedge clk);
        #1;
        req_core.valid = 1'b0;
        req_core.data  = 32'd0;
        t = 0;
        while ((n_beats - b0 < 2) && t < 300) begin
            @(posedge clk);
            t++;
        end
        check("beats_before_reset", 128'(n_beats - b0), 128'd2);
        #1;
        rst = 1'b1;
        @(negedge clk);
        idle_chk("idle_mid_fill_reset");
        @(posedge clk);
        #1;
        @(negedge clk);
        idle_chk("idle_mid_fill_reset2");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        idle_chk("idle_after_fill_reset");
        @(posedge clk);
        #1;
        fetch(32'h0500, 1'b0);
        fetch(32'h0507, 1'b1);

        repeat (3) @(negedge clk);
        check("one_rsp_per_req", 128'(n_rsp), 128'(n_hs));
        finish_now();
    end
endmodule
